// File: rtl/lpc_pkg.sv
// LPC bus nibble codes and the cycle state enumeration shared by the host and the snooper.
package lpc_pkg;

    localparam logic [3:0] LPC_START     = 4'b0000;
    localparam logic [3:0] LPC_CYC_IO_WR = 4'b0010;
    localparam logic [3:0] LPC_ABORT     = 4'b1111;

    localparam logic [3:0] SYNC_READY      = 4'b0000;
    localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
    localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
    localparam logic [3:0] SYNC_ERROR      = 4'b1010;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_START,
        ST_CYCTYPE,
        ST_ADDR0,
        ST_ADDR1,
        ST_ADDR2,
        ST_ADDR3,
        ST_DATA0,
        ST_DATA1,
        ST_TAR0,
        ST_TAR1,
        ST_SYNC,
        ST_PTAR0,
        ST_PTAR1,
        ST_ABORT0,
        ST_ABORT1,
        ST_ABORT2,
        ST_ABORT3
    } lpc_state_t;

endpackage

// File: rtl/lpc_io_write_host.sv
// LPC host initiator for single-byte I/O writes (START..SYNC..TAR, or a 4-cycle abort on SYNC timeout).
// Latency: handshake in cycle 0, START in cycle 1, done in cycle 14 with a zero-wait SYNC (+1 per wait).
// Backpressure: req_ready is high only in IDLE outside reset; one cycle in flight at a time.
module lpc_io_write_host
    import lpc_pkg::*;
#(
    parameter int unsigned SYNC_TIMEOUT   = 8,
    parameter bit          DATA_LSN_FIRST = 1'b1
) (
    input  logic        lpc_clk,
    input  logic        lpc_lreset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        done,
    output logic        err,
    output logic        lpc_lframe_n,
    output logic [3:0]  lpc_lad_o,
    output logic        lpc_lad_oe,
    input  logic [3:0]  lpc_lad_i
);

    lpc_state_t  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  cnt_inc;
    logic        err_flag_q, err_flag_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        handshake;

    logic        lframe_n_d;
    logic [3:0]  lad_o_d;
    logic        lad_oe_d;
    logic        done_d;
    logic        err_d;

    assign req_ready = (state_q == ST_IDLE) && !lpc_lreset;
    assign handshake = req_valid && req_ready;
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        addr_d     = addr_q;
        data_d     = data_q;

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    addr_d     = req_addr;
                    data_d     = req_data;
                    err_flag_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START:   state_d = ST_CYCTYPE;
            ST_CYCTYPE: state_d = ST_ADDR0;
            ST_ADDR0:   state_d = ST_ADDR1;
            ST_ADDR1:   state_d = ST_ADDR2;
            ST_ADDR2:   state_d = ST_ADDR3;
            ST_ADDR3:   state_d = ST_DATA0;
            ST_DATA0:   state_d = ST_DATA1;
            ST_DATA1:   state_d = ST_TAR0;
            ST_TAR0:    state_d = ST_TAR1;
            ST_TAR1: begin
                cnt_d   = '0;
                state_d = ST_SYNC;
            end
            ST_SYNC: begin
                case (lpc_lad_i)
                    SYNC_READY: state_d = ST_PTAR0;
                    SYNC_ERROR: begin
                        err_flag_d = 1'b1;
                        state_d    = ST_PTAR0;
                    end
                    // Long wait is unbounded by design: the counter holds.
                    SYNC_LONG_WAIT: cnt_d = cnt_q;
                    default: begin
                        if (cnt_inc == 9'(SYNC_TIMEOUT)) begin
                            err_flag_d = 1'b1;
                            state_d    = ST_ABORT0;
                        end else begin
                            cnt_d = cnt_inc[7:0];
                        end
                    end
                endcase
            end
            ST_PTAR0:  state_d = ST_PTAR1;
            ST_PTAR1:  state_d = ST_IDLE;
            ST_ABORT0: state_d = ST_ABORT1;
            ST_ABORT1: state_d = ST_ABORT2;
            ST_ABORT2: state_d = ST_ABORT3;
            ST_ABORT3: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Bus outputs are registered, so they are decoded from the state being entered.
        lframe_n_d = 1'b1;
        lad_o_d    = LPC_ABORT;
        lad_oe_d   = 1'b0;
        case (state_d)
            ST_START: begin
                lframe_n_d = 1'b0;
                lad_oe_d   = 1'b1;
                lad_o_d    = LPC_START;
            end
            ST_CYCTYPE: begin
                lad_oe_d = 1'b1;
                lad_o_d  = LPC_CYC_IO_WR;
            end
            ST_ADDR0: begin
                lad_oe_d = 1'b1;
                lad_o_d  = addr_q[15:12];
            end
            ST_ADDR1: begin
                lad_oe_d = 1'b1;
                lad_o_d  = addr_q[11:8];
            end
            ST_ADDR2: begin
                lad_oe_d = 1'b1;
                lad_o_d  = addr_q[7:4];
            end
            ST_ADDR3: begin
                lad_oe_d = 1'b1;
                lad_o_d  = addr_q[3:0];
            end
            ST_DATA0: begin
                lad_oe_d = 1'b1;
                lad_o_d  = DATA_LSN_FIRST ? data_q[3:0] : data_q[7:4];
            end
            ST_DATA1: begin
                lad_oe_d = 1'b1;
                lad_o_d  = DATA_LSN_FIRST ? data_q[7:4] : data_q[3:0];
            end
            ST_TAR0: begin
                lad_oe_d = 1'b1;
                lad_o_d  = LPC_ABORT;
            end
            ST_ABORT0, ST_ABORT1, ST_ABORT2, ST_ABORT3: begin
                lframe_n_d = 1'b0;
                lad_oe_d   = 1'b1;
                lad_o_d    = LPC_ABORT;
            end
            default: begin
                lframe_n_d = 1'b1;
                lad_oe_d   = 1'b0;
            end
        endcase

        done_d = (state_q == ST_PTAR1) || (state_q == ST_ABORT3);
        err_d  = done_d && err_flag_d;
    end

    always_ff @(posedge lpc_clk) begin
        if (lpc_lreset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            err_flag_q   <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            lpc_lframe_n <= 1'b1;
            lpc_lad_o    <= LPC_ABORT;
            lpc_lad_oe   <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_flag_q   <= err_flag_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            lpc_lframe_n <= lframe_n_d;
            lpc_lad_o    <= lad_o_d;
            lpc_lad_oe   <= lad_oe_d;
            done         <= done_d;
            err          <= err_d;
        end
    end

endmodule

// File: tb/tb_lpc_io_write_host.sv
// Bench for lpc_io_write_host: directed and random I/O writes against a cycle-list model of the LPC frame.
module tb_lpc_io_write_host;

    localparam int TIMEOUT = 8;

    logic        lpc_clk = 1'b0;
    logic        lpc_lreset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic        done;
    logic        err;
    logic        lpc_lframe_n;
    logic [3:0]  lpc_lad_o;
    logic        lpc_lad_oe;
    logic [3:0]  lpc_lad_i;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       lframe_n;
        logic       oe;
        logic [3:0] lad;
        logic       done;
        logic       err;
    } beat_t;

    beat_t      exp_q[$];
    logic [3:0] sync_q[$];

    lpc_io_write_host #(
        .SYNC_TIMEOUT   (TIMEOUT),
        .DATA_LSN_FIRST (1'b1)
    ) dut (
        .lpc_clk      (lpc_clk),
        .lpc_lreset   (lpc_lreset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .done         (done),
        .err          (err),
        .lpc_lframe_n (lpc_lframe_n),
        .lpc_lad_o    (lpc_lad_o),
        .lpc_lad_oe   (lpc_lad_oe),
        .lpc_lad_i    (lpc_lad_i)
    );

    always #5 lpc_clk = ~lpc_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_beat(input logic l, input logic o, input logic [3:0] lad,
                                      input logic dn, input logic er);
        beat_t b;
        b.lframe_n = l;
        b.oe       = o;
        b.lad      = lad;
        b.done     = dn;
        b.err      = er;
        exp_q.push_back(b);
    endfunction

    // One entry per cycle after the handshake; the last entry is the done cycle.
    function automatic void build_model(input logic [15:0] a, input logic [7:0] d);
        int         waits;
        int         k;
        logic [3:0] r;
        bit         fail;
        bit         aborted;
        bit         fin;
        exp_q.delete();
        push_beat(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        push_beat(1'b1, 1'b1, 4'h2, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) push_beat(1'b1, 1'b1, a[4*i +: 4], 1'b0, 1'b0);
        push_beat(1'b1, 1'b1, d[3:0], 1'b0, 1'b0);
        push_beat(1'b1, 1'b1, d[7:4], 1'b0, 1'b0);
        push_beat(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        push_beat(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        waits = 0; k = 0; fail = 1'b0; aborted = 1'b0; fin = 1'b0;
        while (!fin) begin
            push_beat(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
            r = (k < sync_q.size()) ? sync_q[k] : 4'hF;
            k++;
            if (r == 4'h0) fin = 1'b1;
            else if (r == 4'hA) begin
                fail = 1'b1;
                fin  = 1'b1;
            end else if (r != 4'h6) begin
                waits++;
                if (waits == TIMEOUT) begin
                    fail    = 1'b1;
                    aborted = 1'b1;
                    fin     = 1'b1;
                end
            end
        end
        if (aborted) begin
            for (int i = 0; i < 4; i++) push_beat(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        end else begin
            for (int i = 0; i < 2; i++) push_beat(1'b1, 1'b0, 4'hF, 1'b0, 1'b0);
        end
        push_beat(1'b1, 1'b0, 4'hF, 1'b1, fail);
    endfunction

    // Entered and left at a falling edge; returns in the done cycle so a caller may chain.
    task automatic run_txn(input logic [15:0] a, input logic [7:0] d, input int rst_at);
        beat_t e;
        build_model(a, d);
        lpc_lad_i = 4'hF;
        chk("req_ready_before_hs", {15'd0, req_ready}, 16'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        @(posedge lpc_clk);
        for (int c = 1; c <= exp_q.size(); c++) begin
            @(negedge lpc_clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_addr  = 16'($urandom);
                req_data  = 8'($urandom);
            end
            e = exp_q[c-1];
            chk($sformatf("lframe_n c%0d", c), {15'd0, lpc_lframe_n}, {15'd0, e.lframe_n});
            chk($sformatf("lad_oe c%0d", c), {15'd0, lpc_lad_oe}, {15'd0, e.oe});
            if (e.oe) chk($sformatf("lad_o c%0d", c), {12'd0, lpc_lad_o}, {12'd0, e.lad});
            chk($sformatf("done c%0d", c), {15'd0, done}, {15'd0, e.done});
            chk($sformatf("err c%0d", c), {15'd0, err}, {15'd0, e.err});
            lpc_lad_i = (c >= 11 && (c - 11) < sync_q.size()) ? sync_q[c-11] : 4'hF;
            if (c == rst_at) begin
                lpc_lreset = 1'b1;
                @(negedge lpc_clk);
                chk("midrst_lframe_n", {15'd0, lpc_lframe_n}, 16'd1);
                chk("midrst_oe", {15'd0, lpc_lad_oe}, 16'd0);
                chk("midrst_lad", {12'd0, lpc_lad_o}, 16'hF);
                chk("midrst_done", {15'd0, done}, 16'd0);
                chk("midrst_ready", {15'd0, req_ready}, 16'd0);
                lpc_lreset = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge lpc_clk);
                    chk("postrst_done", {15'd0, done}, 16'd0);
                    chk("postrst_lframe_n", {15'd0, lpc_lframe_n}, 16'd1);
                end
                chk("postrst_ready", {15'd0, req_ready}, 16'd1);
                return;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] codes[6];
        codes[0] = 4'h0; codes[1] = 4'h5; codes[2] = 4'h6;
        codes[3] = 4'hA; codes[4] = 4'hF; codes[5] = 4'h3;

        lpc_lreset = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 16'h1234;
        req_data   = 8'h77;
        lpc_lad_i  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge lpc_clk);
            chk("rst_lframe_n", {15'd0, lpc_lframe_n}, 16'd1);
            chk("rst_oe", {15'd0, lpc_lad_oe}, 16'd0);
            chk("rst_ready", {15'd0, req_ready}, 16'd0);
            chk("rst_done", {15'd0, done}, 16'd0);
        end
        lpc_lreset = 1'b0;
        req_valid  = 1'b0;
        @(negedge lpc_clk);
        chk("ready_after_reset", {15'd0, req_ready}, 16'd1);

        // Zero-wait write to port 0x80
        sync_q = '{4'h0};
        run_txn(16'h0080, 8'h5A, 0);
        @(negedge lpc_clk);

        // Two short waits
        sync_q = '{4'h5, 4'h5, 4'h0};
        run_txn(16'h0080, 8'h3C, 0);
        @(negedge lpc_clk);

        // Long waits well beyond the timeout
        sync_q.delete();
        for (int i = 0; i < 20; i++) sync_q.push_back(4'h6);
        sync_q.push_back(4'h0);
        run_txn(16'h02F8, 8'hE1, 0);
        @(negedge lpc_clk);

        // No response: timeout and abort
        sync_q.delete();
        run_txn(16'h0CF9, 8'h06, 0);
        @(negedge lpc_clk);

        // Error SYNC, then a back-to-back request accepted in the done cycle
        sync_q = '{4'h5, 4'hA};
        run_txn(16'h0070, 8'h81, 0);
        sync_q = '{4'h0};
        run_txn(16'h0071, 8'h42, 0);
        @(negedge lpc_clk);

        // Reset during ADDR2 (cycle 5 after the handshake)
        sync_q = '{4'h0};
        run_txn(16'hBEEF, 8'hC3, 5);
        sync_q = '{4'h0};
        run_txn(16'h0080, 8'hA5, 0);
        @(negedge lpc_clk);

        for (int t = 0; t < 16; t++) begin
            int n;
            sync_q.delete();
            n = $urandom_range(0, 12);
            for (int i = 0; i < n; i++) sync_q.push_back(codes[$urandom_range(0, 5)]);
            run_txn(16'($urandom), 8'($urandom), 0);
            if ($urandom_range(0, 1) == 1) @(negedge lpc_clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
